instruction_decode: RTL and testbench

- Consumer end of the fetch interface. Takes the fetch stage's registered instruction word and PC+1, and drives the fetch stage's redirect inputs `PCJump`/`PCSrc`.
- Decodes the MIPS subset, reads a 32x32 register file, resolves branches and jumps in this stage, and detects load-use hazards.
- Launches a registered ID/EX bundle to execute.

---
 rtl/mips_pkg.sv | 65 ++++++
 rtl/reg_file.sv | 61 ++++++
 rtl/instruction_decode.sv | 163 ++++++++++++++++
 tb/tb_instruction_decode.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset decode stage.
//   - opcode constants for the supported instruction subset
//   - bit positions inside the 7-bit id_ctrl bundle
//   - default widths for PC, data and register addresses
//   - decode helpers: control-bundle generation and "reads rt" test
package mips_pkg;

    localparam int unsigned PC_W_DEF   = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_AW_DEF = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // id_ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, is_rtype}
    localparam int unsigned CTRL_W          = 7;
    localparam int unsigned CTRL_REG_WRITE  = 6;
    localparam int unsigned CTRL_MEM_READ   = 5;
    localparam int unsigned CTRL_MEM_WRITE  = 4;
    localparam int unsigned CTRL_MEM_TO_REG = 3;
    localparam int unsigned CTRL_ALU_SRC    = 2;
    localparam int unsigned CTRL_REG_DST    = 1;
    localparam int unsigned CTRL_IS_RTYPE   = 0;

    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] opcode);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c[CTRL_REG_WRITE] = 1'b1;
                c[CTRL_REG_DST]   = 1'b1;
                c[CTRL_IS_RTYPE]  = 1'b1;
            end
            OP_LW: begin
                c[CTRL_REG_WRITE]  = 1'b1;
                c[CTRL_MEM_READ]   = 1'b1;
                c[CTRL_MEM_TO_REG] = 1'b1;
                c[CTRL_ALU_SRC]    = 1'b1;
            end
            OP_SW: begin
                c[CTRL_MEM_WRITE] = 1'b1;
                c[CTRL_ALU_SRC]   = 1'b1;
            end
            OP_ADDI: begin
                c[CTRL_REG_WRITE] = 1'b1;
                c[CTRL_ALU_SRC]   = 1'b1;
            end
            // beq/bne/j and unknown opcodes carry no control
            default: c = '0;
        endcase
        return c;
    endfunction

    // Opcodes that consume rt as a source operand (relevant to load-use hazards)
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 2^REG_AW x DATA_W register file.
//   clk        : write clock (rising edge)
//   reset      : asynchronous active-low clear of all registers
//   we/waddr/wdata : single write port
//   raddr_a/rdata_a, raddr_b/rdata_b : asynchronous read ports
// Register 0 is hard-wired to zero. A read of the register being written in
// the same cycle returns the write data (write-through).
module reg_file
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int unsigned NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = '0;
        if (raddr_a == '0) begin
            rdata_a = '0;
        end else if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = mem[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b == '0) begin
            rdata_b = '0;
        end else if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = mem[raddr_b];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// MIPS-subset instruction decode stage.
// Decodes the fetch register's instruction, reads the register file, resolves
// beq/bne/j in this stage (driving the fetch redirect), detects load-use
// hazards and launches a registered ID/EX bundle on the falling clock edge.
//
// Ports:
//   clk, reset            : clock; asynchronous active-low reset
//   Instruction, PCNextReg: instruction word and its PC+1 from fetch
//   wb_we/wb_addr/wb_data : register-file writeback
//   ex_mem_read, ex_rt    : load currently in EX and its destination
//   PCJump, PCSrc         : combinational redirect target / select
//   stall                 : combinational hold for fetch PC and fetch register
//   id_*                  : registered ID/EX bundle (all zero = bubble)
//
// Build option: BRANCH_DELAY_SLOT_EN. When defined, the instruction after a
// taken branch/jump executes (delay slot). When undefined, it is squashed.
module instruction_decode
    import mips_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] Instruction,
    input  logic [PC_W-1:0]   PCNextReg,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    output logic [PC_W-1:0]   PCJump,
    output logic              PCSrc,
    output logic              stall,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm,
    output logic [REG_AW-1:0] id_rs,
    output logic [REG_AW-1:0] id_rt,
    output logic [REG_AW-1:0] id_rd,
    output logic [5:0]        id_funct,
    output logic [CTRL_W-1:0] id_ctrl
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              hazard;
    logic              taken;
    logic [PC_W-1:0]   target;
    logic              squash_q;
    logic              bubble;

    assign opcode  = Instruction[31:26];
    assign rs      = Instruction[25:21];
    assign rt      = Instruction[20:16];
    assign rd      = Instruction[15:11];
    assign funct   = Instruction[5:0];
    assign imm_ext = {{(DATA_W-16){Instruction[15]}}, Instruction[15:0]};

    reg_file #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr_a(rs),
        .raddr_b(rt),
        .rdata_a(rs_data),
        .rdata_b(rt_data)
    );

    always_comb begin
        hazard = ex_mem_read && (ex_rt != '0) &&
                 ((ex_rt == rs) || ((ex_rt == rt) && uses_rt(opcode)));
    end

    always_comb begin
        taken  = 1'b0;
        target = '0;
        case (opcode)
            OP_BEQ: begin
                taken  = (rs_data == rt_data);
                target = PCNextReg + imm_ext[PC_W-1:0]; // wraps modulo 2^PC_W
            end
            OP_BNE: begin
                taken  = (rs_data != rt_data);
                target = PCNextReg + imm_ext[PC_W-1:0];
            end
            OP_J: begin
                taken  = 1'b1;
                target = Instruction[PC_W-1:0];
            end
            default: begin
                taken  = 1'b0;
                target = '0;
            end
        endcase
    end

    // Squash outranks stall, and a stalled branch is not resolved yet.
    always_comb begin
        stall  = reset && !squash_q && hazard;
        PCSrc  = reset && !squash_q && !hazard && taken;
        PCJump = PCSrc ? target : '0;
        bubble = squash_q || hazard;
    end

`ifndef BRANCH_DELAY_SLOT_EN
    // Set on the edge that accepts a redirect; PCSrc is forced low while set,
    // so the flag clears itself on the following edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            squash_q <= 1'b0;
        end else begin
            squash_q <= PCSrc;
        end
    end
`else
    assign squash_q = 1'b0;
`endif

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            id_rs_data <= '0;
            id_rt_data <= '0;
            id_imm     <= '0;
            id_rs      <= '0;
            id_rt      <= '0;
            id_rd      <= '0;
            id_funct   <= '0;
            id_ctrl    <= '0;
        end else if (bubble) begin
            id_rs_data <= '0;
            id_rt_data <= '0;
            id_imm     <= '0;
            id_rs      <= '0;
            id_rt      <= '0;
            id_rd      <= '0;
            id_funct   <= '0;
            id_ctrl    <= '0;
        end else begin
            id_rs_data <= rs_data;
            id_rt_data <= rt_data;
            id_imm     <= imm_ext;
            id_rs      <= rs;
            id_rt      <= rt;
            id_rd      <= rd;
            id_funct   <= funct;
            id_ctrl    <= decode_ctrl(opcode);
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
`timescale 1ns/1ps
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction;
    logic [9:0]  PCNextReg;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic [9:0]  PCJump;
    logic        PCSrc;
    logic        stall;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [6:0]  id_ctrl;

    int passed = 0;
    int total  = 0;

    // Encodings
    localparam logic [31:0] I_NOP        = 32'h0000_0000;
    localparam logic [31:0] I_ADDI_4_3_1 = 32'h2064_0001; // addi r4,r3,1
    localparam logic [31:0] I_ADDI_6_5_M = 32'h20A6_FFFF; // addi r6,r5,-1
    localparam logic [31:0] I_ADDI_4_0_0 = 32'h2004_0000; // addi r4,r0,0
    localparam logic [31:0] I_ADDI_8_3_1 = 32'h2068_0001; // addi r8,r3,1
    localparam logic [31:0] I_BEQ_1_2_M3 = 32'h1022_FFFD; // beq r1,r2,-3
    localparam logic [31:0] I_BEQ_1_1_5  = 32'h1021_0005; // beq r1,r1,5
    localparam logic [31:0] I_BEQ_1_3_5  = 32'h1023_0005; // beq r1,r3,5
    localparam logic [31:0] I_BNE_1_2_5  = 32'h1422_0005; // bne r1,r2,5
    localparam logic [31:0] I_BNE_1_3_5  = 32'h1423_0005; // bne r1,r3,5
    localparam logic [31:0] I_BNE_8_1_2  = 32'h1501_0002; // bne r8,r1,2
    localparam logic [31:0] I_J_155      = 32'h0800_0155; // j 0x155
    localparam logic [31:0] I_ADD_9_8_1  = 32'h0101_4820; // add r9,r8,r1
    localparam logic [31:0] I_ADD_9_0_1  = 32'h0001_4820; // add r9,r0,r1
    localparam logic [31:0] I_SW_8_3     = 32'hAC68_0000; // sw r8,0(r3)
    localparam logic [31:0] I_LW_5_3_4   = 32'h8C65_0004; // lw r5,4(r3)
    localparam logic [31:0] I_BAD        = 32'hFC00_002A; // unknown opcode

    localparam logic [6:0] C_RTYPE = 7'b1000011;
    localparam logic [6:0] C_LW    = 7'b1101100;
    localparam logic [6:0] C_SW    = 7'b0010100;
    localparam logic [6:0] C_ADDI  = 7'b1000100;

    instruction_decode dut (
        .clk        (clk),
        .reset      (reset),
        .Instruction(Instruction),
        .PCNextReg  (PCNextReg),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_mem_read(ex_mem_read),
        .ex_rt      (ex_rt),
        .PCJump     (PCJump),
        .PCSrc      (PCSrc),
        .stall      (stall),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_imm     (id_imm),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_funct   (id_funct),
        .id_ctrl    (id_ctrl)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change 1ns after the falling (ID/EX) edge
    task automatic next_cycle;
        @(negedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        Instruction = I_NOP;
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        next_cycle();
        wb_we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; Instruction = I_BEQ_1_1_5; PCNextReg = 10'd3;
        ex_mem_read = 1'b1; ex_rt = 5'd1;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (3) next_cycle();
        #1;
        total++; if (PCSrc !== 1'b0) $display("FAIL rst_pcsrc got %0d want 0", PCSrc); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got %0d want 0", stall); else passed++;
        total++; if (PCJump !== 10'd0) $display("FAIL rst_pcjump got %0d want 0", PCJump); else passed++;
        total++; if (id_ctrl !== 7'd0 || id_rs_data !== 32'd0 || id_imm !== 32'd0 || id_rs !== 5'd0)
            $display("FAIL rst_idex got ctrl=%h rs_data=%h imm=%h rs=%0d want all 0",
                     id_ctrl, id_rs_data, id_imm, id_rs);
        else passed++;
        ex_mem_read = 1'b0; Instruction = I_ADDI_6_5_M; reset = 1'b1;
        next_cycle();
        total++; if (id_rs_data !== 32'd0) $display("FAIL rst_r5 got %h want 0", id_rs_data); else passed++;
        total++; if (id_imm !== 32'hFFFF_FFFF) $display("FAIL rst_imm got %h want ffffffff", id_imm); else passed++;
        total++; if (id_ctrl !== C_ADDI || id_rs !== 5'd5 || id_rt !== 5'd6)
            $display("FAIL rst_addi got ctrl=%h rs=%0d rt=%0d want 44 5 6", id_ctrl, id_rs, id_rt);
        else passed++;
    endtask

    task automatic test_writeback;
        wb_write(5'd3, 32'h0000_00AA);
        Instruction = I_ADDI_4_3_1;
        next_cycle();
        total++; if (id_rs_data !== 32'hAA) $display("FAIL wb_read got %h want aa", id_rs_data); else passed++;
        total++; if (id_imm !== 32'd1 || id_ctrl !== C_ADDI || id_rt !== 5'd4)
            $display("FAIL wb_addi got imm=%h ctrl=%h rt=%0d want 1 44 4", id_imm, id_ctrl, id_rt);
        else passed++;
        // Same-cycle writeback to the source register
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
        next_cycle();
        wb_we = 1'b0;
        total++; if (id_rs_data !== 32'h55) $display("FAIL wb_samecyc got %h want 55", id_rs_data); else passed++;
        // Writes to r0 are ignored
        wb_write(5'd0, 32'hDEAD_BEEF);
        Instruction = I_ADDI_4_0_0;
        next_cycle();
        total++; if (id_rs_data !== 32'd0) $display("FAIL wb_r0 got %h want 0", id_rs_data); else passed++;
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        // Combinational write-through seen by branch compare before the write edge
        Instruction = I_BEQ_1_2_M3; PCNextReg = 10'd1;
        wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd9;
        #1;
        total++; if (PCSrc !== 1'b0) $display("FAIL bypass_rt got %0d want 0", PCSrc); else passed++;
        wb_addr = 5'd1;
        #1;
        total++; if (PCSrc !== 1'b0) $display("FAIL bypass_rs got %0d want 0", PCSrc); else passed++;
        wb_we = 1'b0;
        #1;
        total++; if (PCSrc !== 1'b1) $display("FAIL bypass_off got %0d want 1", PCSrc); else passed++;
        Instruction = I_NOP;
        next_cycle();
    endtask

    task automatic test_branch;
        Instruction = I_BEQ_1_2_M3; PCNextReg = 10'd1;
        #2;
        total++; if (PCSrc !== 1'b1) $display("FAIL beq_pcsrc got %0d want 1", PCSrc); else passed++;
        total++; if (PCJump !== 10'd1022) $display("FAIL beq_wrap got %0d want 1022", PCJump); else passed++;
        next_cycle();
        total++; if (id_ctrl !== 7'd0 || id_rs !== 5'd1 || id_imm !== 32'hFFFF_FFFD)
            $display("FAIL beq_launch got ctrl=%h rs=%0d imm=%h want 0 1 fffffffd", id_ctrl, id_rs, id_imm);
        else passed++;
        Instruction = I_J_155; PCNextReg = 10'd5;
        #2;
`ifdef BRANCH_DELAY_SLOT_EN
        total++; if (PCSrc !== 1'b1 || PCJump !== 10'h155)
            $display("FAIL j_slot got pcsrc=%0d pcjump=%h want 1 155", PCSrc, PCJump);
        else passed++;
        next_cycle();
        total++; if (id_imm !== 32'h155) $display("FAIL j_slot_launch got %h want 155", id_imm); else passed++;
`else
        total++; if (PCSrc !== 1'b0 || PCJump !== 10'd0)
            $display("FAIL squash_pcsrc got pcsrc=%0d pcjump=%h want 0 0", PCSrc, PCJump);
        else passed++;
        next_cycle();
        total++; if (id_imm !== 32'd0 || id_ctrl !== 7'd0)
            $display("FAIL squash_bubble got imm=%h ctrl=%h want 0 0", id_imm, id_ctrl);
        else passed++;
`endif
        Instruction = I_ADDI_4_3_1;
        #2;
        total++; if (PCSrc !== 1'b0) $display("FAIL after_j_pcsrc got %0d want 0", PCSrc); else passed++;
        next_cycle();
        total++; if (id_ctrl !== C_ADDI || id_rs_data !== 32'h55)
            $display("FAIL after_j_addi got ctrl=%h rs_data=%h want 44 55", id_ctrl, id_rs_data);
        else passed++;
        // Not-taken branches
        Instruction = I_BNE_1_2_5;
        #1;
        total++; if (PCSrc !== 1'b0 || PCJump !== 10'd0)
            $display("FAIL bne_nt got pcsrc=%0d pcjump=%0d want 0 0", PCSrc, PCJump);
        else passed++;
        Instruction = I_BEQ_1_3_5;
        #1;
        total++; if (PCSrc !== 1'b0) $display("FAIL beq_nt got %0d want 0", PCSrc); else passed++;
        // Taken bne with forward wrap: 1020 + 5 = 1
        Instruction = I_BNE_1_3_5; PCNextReg = 10'd1020;
        #1;
        total++; if (PCSrc !== 1'b1 || PCJump !== 10'd1)
            $display("FAIL bne_wrap got pcsrc=%0d pcjump=%0d want 1 1", PCSrc, PCJump);
        else passed++;
        next_cycle();
        // Shadow instruction has a load-use hazard
        Instruction = I_ADD_9_8_1; ex_mem_read = 1'b1; ex_rt = 5'd8;
        #2;
`ifdef BRANCH_DELAY_SLOT_EN
        total++; if (stall !== 1'b1) $display("FAIL slot_stall got %0d want 1", stall); else passed++;
`else
        total++; if (stall !== 1'b0) $display("FAIL squash_over_stall got %0d want 0", stall); else passed++;
`endif
        next_cycle();
        total++; if (id_ctrl !== 7'd0) $display("FAIL shadow_bubble got %h want 0", id_ctrl); else passed++;
        ex_mem_read = 1'b0;
        Instruction = I_NOP;
        next_cycle();
    endtask

    task automatic test_load_use;
        Instruction = I_ADD_9_8_1; ex_mem_read = 1'b1; ex_rt = 5'd8;
        #2;
        total++; if (stall !== 1'b1 || PCSrc !== 1'b0)
            $display("FAIL lu_stall got stall=%0d pcsrc=%0d want 1 0", stall, PCSrc);
        else passed++;
        next_cycle();
        total++; if (id_ctrl !== 7'd0 || id_rd !== 5'd0)
            $display("FAIL lu_bubble got ctrl=%h rd=%0d want 0 0", id_ctrl, id_rd);
        else passed++;
        ex_mem_read = 1'b0;
        #2;
        total++; if (stall !== 1'b0) $display("FAIL lu_release got %0d want 0", stall); else passed++;
        next_cycle();
        total++; if (id_ctrl !== C_RTYPE || id_rd !== 5'd9 || id_funct !== 6'h20 || id_rs !== 5'd8)
            $display("FAIL lu_add got ctrl=%h rd=%0d funct=%h rs=%0d want 43 9 20 8",
                     id_ctrl, id_rd, id_funct, id_rs);
        else passed++;
        total++; if (id_rt_data !== 32'd7 || id_rs_data !== 32'd0)
            $display("FAIL lu_add_data got rt=%h rs=%h want 7 0", id_rt_data, id_rs_data);
        else passed++;
        ex_mem_read = 1'b1; ex_rt = 5'd0; Instruction = I_ADD_9_0_1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL lu_rt0 got %0d want 0", stall); else passed++;
        ex_rt = 5'd8; Instruction = I_ADDI_8_3_1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL lu_addi_dest got %0d want 0", stall); else passed++;
        Instruction = I_SW_8_3;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL lu_sw_rt got %0d want 1", stall); else passed++;
        next_cycle();
        ex_mem_read = 1'b0;
        next_cycle();
        total++; if (id_ctrl !== C_SW || id_rt !== 5'd8)
            $display("FAIL dec_sw got ctrl=%h rt=%0d want 14 8", id_ctrl, id_rt);
        else passed++;
    endtask

    task automatic test_decode;
        Instruction = I_LW_5_3_4;
        next_cycle();
        total++; if (id_ctrl !== C_LW || id_imm !== 32'd4 || id_rt !== 5'd5)
            $display("FAIL dec_lw got ctrl=%h imm=%h rt=%0d want 6c 4 5", id_ctrl, id_imm, id_rt);
        else passed++;
        Instruction = I_BAD;
        #2;
        total++; if (PCSrc !== 1'b0) $display("FAIL dec_bad_pcsrc got %0d want 0", PCSrc); else passed++;
        next_cycle();
        total++; if (id_ctrl !== 7'd0) $display("FAIL dec_bad got %h want 0", id_ctrl); else passed++;
    endtask

    task automatic test_stall_branch;
        Instruction = I_BNE_8_1_2; PCNextReg = 10'd10; ex_mem_read = 1'b1; ex_rt = 5'd8;
        #2;
        total++; if (stall !== 1'b1 || PCSrc !== 1'b0 || PCJump !== 10'd0)
            $display("FAIL sb_first got stall=%0d pcsrc=%0d pcjump=%0d want 1 0 0", stall, PCSrc, PCJump);
        else passed++;
        next_cycle();
        total++; if (id_ctrl !== 7'd0 || id_rs !== 5'd0)
            $display("FAIL sb_bubble got ctrl=%h rs=%0d want 0 0", id_ctrl, id_rs);
        else passed++;
        ex_mem_read = 1'b0;
        #2;
        total++; if (stall !== 1'b0 || PCSrc !== 1'b1 || PCJump !== 10'd12)
            $display("FAIL sb_second got stall=%0d pcsrc=%0d pcjump=%0d want 0 1 12", stall, PCSrc, PCJump);
        else passed++;
        next_cycle();
        total++; if (id_rs !== 5'd8) $display("FAIL sb_launch got rs=%0d want 8", id_rs); else passed++;
        Instruction = I_ADDI_4_3_1;
        next_cycle();
`ifdef BRANCH_DELAY_SLOT_EN
        total++; if (id_ctrl !== C_ADDI) $display("FAIL sb_slot got %h want 44", id_ctrl); else passed++;
`else
        total++; if (id_ctrl !== 7'd0) $display("FAIL sb_squash got %h want 0", id_ctrl); else passed++;
`endif
    endtask

    task automatic test_reset_mid;
        Instruction = I_J_155;
        #2;
        total++; if (PCSrc !== 1'b1) $display("FAIL rm_j got %0d want 1", PCSrc); else passed++;
        next_cycle();
        total++; if (id_imm !== 32'h155) $display("FAIL rm_j_launch got %h want 155", id_imm); else passed++;
        // Short reset pulse between falling edges must discard any pending squash
        reset = 1'b0;
        #1;
        total++; if (id_imm !== 32'd0 || PCSrc !== 1'b0)
            $display("FAIL rm_async got imm=%h pcsrc=%0d want 0 0", id_imm, PCSrc);
        else passed++;
        reset = 1'b1; Instruction = I_ADDI_4_3_1;
        #1;
        total++; if (PCSrc !== 1'b0) $display("FAIL rm_no_redirect got %0d want 0", PCSrc); else passed++;
        next_cycle();
        total++; if (id_ctrl !== C_ADDI || id_rs_data !== 32'd0)
            $display("FAIL rm_after got ctrl=%h rs_data=%h want 44 0", id_ctrl, id_rs_data);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_writeback();
        test_branch();
        test_load_use();
        test_decode();
        test_stall_branch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
